tmr_voter: RTL and testbench

//   Triple-modular-redundancy word voter. Takes three copies of a data word from

---
 rtl/tmr_voter.sv | 65 ++++++
 tb/tb_tmr_voter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_voter.sv
// Triple-modular-redundancy word voter: zero-latency bitwise 2-of-3 majority with registered lane diagnostics.
// Optional per-lane saturating error counters are enabled by defining TMR_ERR_CNT_EN.
module tmr_voter #(
  parameter int WIDTH = 4
`ifdef TMR_ERR_CNT_EN
  , parameter int CNT_WIDTH = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic [WIDTH-1:0] data_3,
  output logic [WIDTH-1:0] tmr_out,
  output logic [2:0]       lane_err,
  output logic             multi_err
`ifdef TMR_ERR_CNT_EN
  , output logic [CNT_WIDTH-1:0] err_cnt_1
  , output logic [CNT_WIDTH-1:0] err_cnt_2
  , output logic [CNT_WIDTH-1:0] err_cnt_3
`endif
);

  logic [2:0] mis;
  logic       mis_multi;

  // The vote stays live through reset so the datapath is never blocked.
  assign tmr_out = (data_1 & data_2) | (data_1 & data_3) | (data_2 & data_3);

  assign mis[0]    = |(data_1 ^ tmr_out);
  assign mis[1]    = |(data_2 ^ tmr_out);
  assign mis[2]    = |(data_3 ^ tmr_out);
  assign mis_multi = (mis[0] & mis[1]) | (mis[0] & mis[2]) | (mis[1] & mis[2]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_err  <= 3'b000;
      multi_err <= 1'b0;
    end else begin
      lane_err  <= mis;
      multi_err <= mis_multi;
    end
  end

`ifdef TMR_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] cnt [3];

  // NOTE: the counter array is three registers, not a RAM, so it can and must be reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (mis[i] && (cnt[i] != {CNT_WIDTH{1'b1}})) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign err_cnt_1 = cnt[0];
  assign err_cnt_2 = cnt[1];
  assign err_cnt_3 = cnt[2];
`endif

endmodule

// File: tb/tb_tmr_voter.sv
// Self-checking bench for tmr_voter: directed vectors plus randomized lanes against a per-bit vote model.
// Counter checks are compiled only when TMR_ERR_CNT_EN is defined.
module tb_tmr_voter;
  localparam int W       = 4;
  localparam int CNT_MAX = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d1, d2, d3;
  logic [W-1:0] tmr_out;
  logic [2:0]   lane_err;
  logic         multi_err;
`ifdef TMR_ERR_CNT_EN
  logic [7:0]   err_cnt_1, err_cnt_2, err_cnt_3;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt [3];

  always #5 clk = ~clk;

  tmr_voter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_1    (d1),
    .data_2    (d2),
    .data_3    (d3),
    .tmr_out   (tmr_out),
    .lane_err  (lane_err),
    .multi_err (multi_err)
`ifdef TMR_ERR_CNT_EN
    , .err_cnt_1 (err_cnt_1)
    , .err_cnt_2 (err_cnt_2)
    , .err_cnt_3 (err_cnt_3)
`endif
  );

  // Reference: each output bit is 1 when at least two lanes carry a 1.
  function automatic logic [W-1:0] ref_vote(input logic [W-1:0] a, b, c);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      v[i] = (ones >= 2);
    end
    return v;
  endfunction

  function automatic logic [2:0] ref_mis(input logic [W-1:0] a, b, c);
    logic [W-1:0] v;
    v = ref_vote(a, b, c);
    return {c != v, b != v, a != v};
  endfunction

  function automatic logic ref_multi(input logic [2:0] m);
    return $countones(m) >= 2;
  endfunction

  // Advance one clock; the counter model follows the lanes held across the edge.
  task automatic step();
    logic [2:0] m;
    @(posedge clk);
    m = ref_mis(d1, d2, d3);
    for (int i = 0; i < 3; i++) begin
      if (rst) exp_cnt[i] = 0;
      else if (m[i] && exp_cnt[i] < CNT_MAX) exp_cnt[i]++;
    end
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, b, c);
    d1 = a; d2 = b; d3 = c;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'b1010, 4'b0110, 4'b0011);
    n_tests++;
    if (tmr_out !== 4'b0010) begin
      n_fail++; $display("FAIL reset_vote: got %b expected %b", tmr_out, 4'b0010);
    end
    step(); step();
    n_tests++;
    if (lane_err !== 3'b000 || multi_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got lane_err=%b multi_err=%b expected 000/0", lane_err, multi_err);
    end
`ifdef TMR_ERR_CNT_EN
    n_tests++;
    if (err_cnt_1 !== 8'd0 || err_cnt_2 !== 8'd0 || err_cnt_3 !== 8'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", err_cnt_1, err_cnt_2, err_cnt_3);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] a [5] = '{4'b1111, 4'b1011, 4'b1111, 4'b1011, 4'b1010};
    logic [W-1:0] b [5] = '{4'b1011, 4'b1001, 4'b1010, 4'b1001, 4'b1011};
    logic [W-1:0] c [5] = '{4'b1111, 4'b1011, 4'b1111, 4'b1001, 4'b1111};
    logic [W-1:0] v [5] = '{4'b1111, 4'b1011, 4'b1111, 4'b1001, 4'b1011};
    logic [2:0]   le[5] = '{3'b010,  3'b010,  3'b010,  3'b001,  3'b101};
    logic         me[5] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(a[i], b[i], c[i]);
      n_tests++;
      if (tmr_out !== v[i]) begin
        n_fail++; $display("FAIL directed_vote[%0d]: got %b expected %b", i, tmr_out, v[i]);
      end
      step();
      n_tests++;
      if (lane_err !== le[i] || multi_err !== me[i]) begin
        n_fail++; $display("FAIL directed_flags[%0d]: got %b/%b expected %b/%b", i, lane_err, multi_err, le[i], me[i]);
      end
    end
  endtask

  // Back-to-back random vectors: mostly clean or single-lane faults, some fully random.
  task automatic test_random();
    logic [W-1:0] a, b, c, x;
    logic [2:0]   m;
    for (int i = 0; i < 200; i++) begin
      x = W'($urandom);
      a = x; b = x; c = x;
      case ($urandom_range(0, 3))
        0: ;
        1: a = x ^ W'($urandom_range(1, 15));
        2: begin b = W'($urandom); c = W'($urandom); end
        default: c = x ^ W'($urandom_range(1, 15));
      endcase
      drive(a, b, c);
      n_tests++;
      if (tmr_out !== ref_vote(a, b, c)) begin
        n_fail++; $display("FAIL random_vote[%0d]: got %b expected %b", i, tmr_out, ref_vote(a, b, c));
      end
      m = ref_mis(a, b, c);
      step();
      n_tests++;
      if (lane_err !== m || multi_err !== ref_multi(m)) begin
        n_fail++; $display("FAIL random_flags[%0d]: got %b/%b expected %b/%b", i, lane_err, multi_err, m, ref_multi(m));
      end
`ifdef TMR_ERR_CNT_EN
      n_tests++;
      if (err_cnt_1 !== 8'(exp_cnt[0]) || err_cnt_2 !== 8'(exp_cnt[1]) || err_cnt_3 !== 8'(exp_cnt[2])) begin
        n_fail++; $display("FAIL random_cnt[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                           err_cnt_1, err_cnt_2, err_cnt_3, exp_cnt[0], exp_cnt[1], exp_cnt[2]);
      end
`endif
    end
  endtask

  task automatic test_reset_midrun();
    drive(4'b0110, 4'b1001, 4'b0111);
    step();
    rst = 1'b1;
    drive(4'b0110, 4'b0110, 4'b0110);
    n_tests++;
    if (tmr_out !== 4'b0110) begin
      n_fail++; $display("FAIL midrun_vote_in_reset: got %b expected 0110", tmr_out);
    end
    drive(4'b0110, 4'b1001, 4'b0111);
    step();
    n_tests++;
    if (lane_err !== 3'b000 || multi_err !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset_flags: got %b/%b expected 000/0", lane_err, multi_err);
    end
`ifdef TMR_ERR_CNT_EN
    n_tests++;
    if (err_cnt_1 !== 8'd0 || err_cnt_2 !== 8'd0 || err_cnt_3 !== 8'd0) begin
      n_fail++; $display("FAIL midrun_reset_cnt: got %0d/%0d/%0d expected 0", err_cnt_1, err_cnt_2, err_cnt_3);
    end
`endif
    rst = 1'b0;
    drive(4'b0110, 4'b0110, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (tmr_out !== 4'b0110 || lane_err !== 3'b000 || multi_err !== 1'b0) begin
        n_fail++; $display("FAIL midrun_clean[%0d]: got %b %b/%b expected 0110 000/0", i, tmr_out, lane_err, multi_err);
      end
    end
  endtask

`ifdef TMR_ERR_CNT_EN
  task automatic test_counters();
    logic [W-1:0] x;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      x = W'($urandom);
      drive(x, x ^ W'($urandom_range(1, 15)), x);
      step();
      if (i == 9) begin
        n_tests++;
        if (err_cnt_2 !== 8'd10) begin
          n_fail++; $display("FAIL cnt_partial: got %0d expected 10", err_cnt_2);
        end
      end
    end
    n_tests++;
    if (err_cnt_2 !== 8'd255 || err_cnt_1 !== 8'd0 || err_cnt_3 !== 8'd0) begin
      n_fail++; $display("FAIL cnt_saturate: got %0d/%0d/%0d expected 0/255/0", err_cnt_1, err_cnt_2, err_cnt_3);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    d1 = '0; d2 = '0; d3 = '0;
    test_reset();
    test_directed();
    test_random();
    test_reset_midrun();
`ifdef TMR_ERR_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
